// File: rtl/led_seq_pkg.sv
// ============================================================================
// Module   : led_seq_pkg
// Purpose  : Shared opcodes, field positions, mode and state encodings for
//            the LED pattern sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_seq_pkg;

    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 28;
    localparam int unsigned RUN_BIT = 0;

    localparam logic [3:0] OP_PTR    = 4'h1;
    localparam logic [3:0] OP_DATA   = 4'h2;
    localparam logic [3:0] OP_PERIOD = 4'h3;
    localparam logic [3:0] OP_LENGTH = 4'h4;
    localparam logic [3:0] OP_MODE   = 4'h5;
    localparam logic [3:0] OP_SWAP   = 4'h6;
    localparam logic [3:0] OP_RUN    = 4'h7;

    typedef enum logic [1:0] {
        MODE_LOOP     = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_PINGPONG = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Encoding 3 is reserved and falls back to looping.
    function automatic mode_e decode_mode(input logic [1:0] field);
        case (field)
            2'd1:    return MODE_ONESHOT;
            2'd2:    return MODE_PINGPONG;
            default: return MODE_LOOP;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_pattern_bank.sv
// ============================================================================
// Module   : led_pattern_bank
// Purpose  : Double-buffered pattern store; writes land in the shadow bank,
//            reads come from the active bank, i_swap exchanges the two.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_bank #(
    parameter int N_COL = 28,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [N_COL-1:0] i_wdata,
    input  logic             i_swap,
    input  logic [AW-1:0]    i_raddr,
    output logic [N_COL-1:0] o_rdata
);

    logic [N_COL-1:0] r_mem [2][DEPTH];
    logic             r_sel;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    r_mem[b][d] <= '0;
                end
            end
            r_sel <= 1'b0;
        end else begin
            if (i_we) begin
                r_mem[~r_sel][i_waddr] <= i_wdata;
            end
            if (i_swap) begin
                r_sel <= ~r_sel;
            end
        end
    end

    assign o_rdata = r_mem[r_sel][i_raddr];

endmodule

`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
// ============================================================================
// Module   : led_pattern_sequencer
// Purpose  : Steps through a bank of LED column patterns with programmable
//            dwell in loop, one-shot or ping-pong mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_COL    = 28,
    parameter int DEPTH    = 16,
    parameter int PERIOD_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ena,
    input  logic             i_prm_we,
    input  logic [31:0]      i_prm,
    output logic [N_COL-1:0] o_column,
    output logic             o_toggle_sync,
    output logic             o_head_flag,
    output logic             o_busy,
    output logic             o_swap_pending
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam logic [c_LW-1:0]     c_DEPTH_L = c_LW'(DEPTH);
    localparam logic [PERIOD_W-1:0] c_PER_ONE = PERIOD_W'(1);

    state_e              r_state, w_state;
    mode_e               r_mode, w_mode, r_stg_mode, w_stg_mode;
    logic [c_AW-1:0]     r_idx, w_idx, r_wptr, w_wptr;
    logic [PERIOD_W-1:0] r_dwell, w_dwell, r_period, w_period, r_stg_period, w_stg_period;
    logic [c_LW-1:0]     r_len, w_len, r_stg_len, w_stg_len;
    logic                r_dir_up, w_dir_up, r_swap_pending, w_swap_pending, r_step, w_step;
    logic                w_we, w_swap, w_boundary, w_last, w_dwell_done;
    logic                w_cmd_start, w_cmd_stop, w_cmd_swap;
    logic [3:0]          w_op;
    logic [c_LW-1:0]     w_arg_len;
    logic [PERIOD_W-1:0] w_arg_per;
    logic [N_COL-1:0]    w_rdata;
    logic [N_COL-1:0]    r_column;
    logic                r_toggle, r_head, r_busy;

    led_pattern_bank #(
        .N_COL (N_COL),
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_bank (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdata (i_prm[N_COL-1:0]),
        .i_swap  (w_swap),
        .i_raddr (r_idx),
        .o_rdata (w_rdata)
    );

    assign w_op         = i_prm[OP_MSB:OP_LSB];
    assign w_arg_len    = i_prm[c_AW:0];
    assign w_arg_per    = i_prm[PERIOD_W-1:0];
    assign w_cmd_start  = i_prm_we && (w_op == OP_RUN) &&  i_prm[RUN_BIT];
    assign w_cmd_stop   = i_prm_we && (w_op == OP_RUN) && !i_prm[RUN_BIT];
    assign w_cmd_swap   = i_prm_we && (w_op == OP_SWAP);
    assign w_last       = ({1'b0, r_idx} == (r_len - c_LW'(1)));
    assign w_dwell_done = (r_dwell == (r_period - c_PER_ONE));

    always_comb begin
        w_state        = r_state;
        w_mode         = r_mode;
        w_stg_mode     = r_stg_mode;
        w_idx          = r_idx;
        w_wptr         = r_wptr;
        w_dwell        = r_dwell;
        w_period       = r_period;
        w_stg_period   = r_stg_period;
        w_len          = r_len;
        w_stg_len      = r_stg_len;
        w_dir_up       = r_dir_up;
        w_swap_pending = r_swap_pending;
        w_step         = 1'b0;
        w_we           = 1'b0;
        w_swap         = 1'b0;
        w_boundary     = 1'b0;

        if (i_prm_we) begin
            case (w_op)
                OP_PTR:    w_wptr = i_prm[c_AW-1:0];
                OP_DATA: begin
                    w_we   = 1'b1;
                    w_wptr = r_wptr + 1'b1;
                end
                OP_PERIOD: w_stg_period = (w_arg_per == '0) ? c_PER_ONE : w_arg_per;
                OP_LENGTH: w_stg_len = ((w_arg_len == '0) || (w_arg_len > c_DEPTH_L)) ?
                                       c_DEPTH_L : w_arg_len;
                OP_MODE:   w_stg_mode = decode_mode(i_prm[1:0]);
                default:   ;
            endcase
        end

        case (r_state)
            ST_RUN: begin
                if (w_cmd_stop) begin
                    w_state = ST_IDLE;
                end else if (!w_cmd_start && i_ena) begin
                    if (!w_dwell_done) begin
                        w_dwell = r_dwell + 1'b1;
                    end else begin
                        w_dwell = '0;
                        case (r_mode)
                            MODE_ONESHOT: begin
                                if (w_last) begin
                                    w_state = ST_DONE;
                                end else begin
                                    w_idx  = r_idx + 1'b1;
                                    w_step = 1'b1;
                                end
                            end
                            MODE_PINGPONG: begin
                                w_step = 1'b1;
                                if (r_len == c_LW'(1)) begin
                                    w_idx = '0;
                                end else if (r_dir_up) begin
                                    if (w_last) begin
                                        w_dir_up = 1'b0;
                                        w_idx    = r_idx - 1'b1;
                                    end else begin
                                        w_idx = r_idx + 1'b1;
                                    end
                                end else if (r_idx == '0) begin
                                    w_dir_up = 1'b1;
                                    w_idx    = r_idx + 1'b1;
                                end else begin
                                    w_idx = r_idx - 1'b1;
                                end
                            end
                            default: begin
                                w_step = 1'b1;
                                w_idx  = w_last ? '0 : r_idx + 1'b1;
                            end
                        endcase
                        w_boundary = w_step && (w_idx == '0);
                    end
                end
            end
            default: begin
                if (w_cmd_stop) begin
                    w_state = ST_IDLE;
                end
            end
        endcase

        if (w_cmd_start) begin
            w_state    = ST_RUN;
            w_idx      = '0;
            w_dwell    = '0;
            w_dir_up   = 1'b1;
            w_step     = 1'b1;
            w_boundary = 1'b1;
        end

        // Staged settings and deferred bank swaps only take effect at idx 0.
        if (w_boundary) begin
            w_period = r_stg_period;
            w_len    = r_stg_len;
            w_mode   = r_stg_mode;
            if (r_swap_pending || w_cmd_swap) begin
                w_swap         = 1'b1;
                w_swap_pending = 1'b0;
            end
        end else if (w_cmd_swap) begin
            if (r_state == ST_RUN) begin
                w_swap_pending = 1'b1;
            end else begin
                w_swap         = 1'b1;
                w_swap_pending = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_mode         <= MODE_LOOP;
            r_stg_mode     <= MODE_LOOP;
            r_idx          <= '0;
            r_wptr         <= '0;
            r_dwell        <= '0;
            r_period       <= c_PER_ONE;
            r_stg_period   <= c_PER_ONE;
            r_len          <= c_DEPTH_L;
            r_stg_len      <= c_DEPTH_L;
            r_dir_up       <= 1'b1;
            r_swap_pending <= 1'b0;
            r_step         <= 1'b0;
            r_column       <= '0;
            r_toggle       <= 1'b0;
            r_head         <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_mode         <= w_mode;
            r_stg_mode     <= w_stg_mode;
            r_idx          <= w_idx;
            r_wptr         <= w_wptr;
            r_dwell        <= w_dwell;
            r_period       <= w_period;
            r_stg_period   <= w_stg_period;
            r_len          <= w_len;
            r_stg_len      <= w_stg_len;
            r_dir_up       <= w_dir_up;
            r_swap_pending <= w_swap_pending;
            r_step         <= w_step;
            // Display lags the index by one clock so the bank read is registered.
            r_column       <= ((r_state == ST_RUN) && i_ena) ? w_rdata : '0;
            r_toggle       <= r_toggle ^ r_step;
            r_head         <= (r_state == ST_RUN) && (r_idx == '0);
            r_busy         <= (r_state == ST_RUN);
        end
    end

    assign o_column       = r_column;
    assign o_toggle_sync  = r_toggle;
    assign o_head_flag    = r_head;
    assign o_busy         = r_busy;
    assign o_swap_pending = r_swap_pending;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
// ============================================================================
// Module   : tb_led_pattern_sequencer
// Purpose  : Directed bench; expected display steps are queued and a monitor
//            checks each one when o_toggle_sync flips.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_sequencer;

    localparam logic [3:0] T_PTR = 4'h1, T_DATA = 4'h2, T_PER = 4'h3, T_LEN = 4'h4;
    localparam logic [3:0] T_MODE = 4'h5, T_SWAP = 4'h6, T_RUN = 4'h7;

    logic        i_clk = 1'b0;
    logic        i_rst, i_ena, i_prm_we;
    logic [31:0] i_prm;
    logic [27:0] o_column;
    logic        o_toggle_sync, o_head_flag, o_busy, o_swap_pending;

    typedef struct {
        logic [27:0] col;
        logic        head;
        int          hold;
    } step_t;

    step_t q[$];
    step_t prev;
    bit    have_prev = 1'b0;
    logic  last_tog  = 1'b0;
    int    cnt       = 0;
    int    n_vec     = 0;
    int    n_err     = 0;

    led_pattern_sequencer #(
        .N_COL    (28),
        .DEPTH    (16),
        .PERIOD_W (16)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_ena          (i_ena),
        .i_prm_we       (i_prm_we),
        .i_prm          (i_prm),
        .o_column       (o_column),
        .o_toggle_sync  (o_toggle_sync),
        .o_head_flag    (o_head_flag),
        .o_busy         (o_busy),
        .o_swap_pending (o_swap_pending)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmd(input logic [3:0] op, input logic [27:0] arg);
        @(negedge i_clk);
        i_prm_we = 1'b1;
        i_prm    = {op, arg};
        @(negedge i_clk);
        i_prm_we = 1'b0;
        i_prm    = '0;
    endtask

    task automatic exp_step(input logic [27:0] col, input logic head, input int hold);
        step_t s;
        s.col  = col;
        s.head = head;
        s.hold = hold;
        q.push_back(s);
    endtask

    task automatic wait_q(input int n, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(posedge i_clk);
            if (q.size() <= n) done = 1'b1;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: %0d steps outstanding, required <= %0d", tag, q.size(), n);
        end
    endtask

    // Monitor: each flip of o_toggle_sync marks a new displayed step.
    always @(negedge i_clk) begin
        if (i_rst) begin
            last_tog  = o_toggle_sync;
            have_prev = 1'b0;
            cnt       = 0;
        end else if (o_toggle_sync !== last_tog) begin
            last_tog = o_toggle_sync;
            if (have_prev && prev.hold > 0) chk("hold", cnt, prev.hold);
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL step: unexpected step, column 0x%0h", o_column);
                have_prev = 1'b0;
            end else begin
                prev      = q.pop_front();
                have_prev = 1'b1;
                chk("column", o_column, prev.col);
                chk("head", o_head_flag, prev.head);
            end
            cnt = 1;
        end else begin
            cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        i_rst = 1'b1; i_ena = 1'b1; i_prm_we = 1'b0; i_prm = '0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_column", o_column, 0);
        chk("rst_toggle", o_toggle_sync, 0);
        chk("rst_head", o_head_flag, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_pending", o_swap_pending, 0);

        // Loop, 3 patterns, dwell 4
        cmd(T_PTR, 0); cmd(T_DATA, 28'h1); cmd(T_DATA, 28'h2); cmd(T_DATA, 28'h4);
        cmd(T_LEN, 3); cmd(T_PER, 4); cmd(T_SWAP, 0);
        chk("idle_swap_pending", o_swap_pending, 0);
        exp_step(28'h1, 1, 4); exp_step(28'h2, 0, 4); exp_step(28'h4, 0, 4);
        exp_step(28'h1, 1, 4); exp_step(28'h2, 0, 0);
        cmd(T_RUN, 1);
        wait_q(0, "loop");
        cmd(T_RUN, 0);
        repeat (2) @(negedge i_clk);
        chk("loop_stop_busy", o_busy, 0);
        chk("loop_stop_column", o_column, 0);

        // Ping-pong over the same three patterns
        cmd(T_MODE, 2);
        exp_step(28'h1, 1, 4); exp_step(28'h2, 0, 4); exp_step(28'h4, 0, 4);
        exp_step(28'h2, 0, 4); exp_step(28'h1, 1, 4); exp_step(28'h2, 0, 0);
        cmd(T_RUN, 1);
        wait_q(0, "pingpong");
        cmd(T_RUN, 0);
        repeat (2) @(negedge i_clk);
        chk("pp_stop_head", o_head_flag, 0);

        // One-shot, 2 patterns, dwell 3
        cmd(T_MODE, 1); cmd(T_LEN, 2); cmd(T_PER, 3);
        exp_step(28'h1, 1, 3); exp_step(28'h2, 0, 0);
        cmd(T_RUN, 1);
        wait_q(0, "oneshot");
        repeat (2) @(negedge i_clk);
        chk("oneshot_last_busy", o_busy, 1);
        chk("oneshot_last_column", o_column, 28'h2);
        @(negedge i_clk);
        chk("oneshot_done_busy", o_busy, 0);
        chk("oneshot_done_column", o_column, 0);
        chk("oneshot_done_head", o_head_flag, 0);
        cmd(T_RUN, 0);

        // Deferred swap: active AAA, shadow 555
        cmd(T_MODE, 0); cmd(T_LEN, 2); cmd(T_PER, 4);
        cmd(T_PTR, 0); cmd(T_DATA, 28'hAAA); cmd(T_DATA, 28'hAAA); cmd(T_SWAP, 0);
        cmd(T_PTR, 0); cmd(T_DATA, 28'h555); cmd(T_DATA, 28'h555);
        exp_step(28'hAAA, 1, 4); exp_step(28'hAAA, 0, 4);
        exp_step(28'h555, 1, 4); exp_step(28'h555, 0, 0);
        cmd(T_RUN, 1);
        wait_q(3, "swap_head");
        cmd(T_SWAP, 0);
        chk("swap_pending_set", o_swap_pending, 1);
        wait_q(2, "swap_mid");
        @(negedge i_clk);
        chk("swap_pending_held", o_swap_pending, 1);
        wait_q(1, "swap_applied");
        @(negedge i_clk);
        chk("swap_pending_clear", o_swap_pending, 0);
        wait_q(0, "swap_end");
        cmd(T_RUN, 0);

        // Enable dropped for 10 clocks during the idx-0 dwell
        exp_step(28'h555, 1, 14); exp_step(28'h555, 0, 4); exp_step(28'h555, 1, 0);
        cmd(T_RUN, 1);
        wait_q(2, "ena_head");
        @(negedge i_clk);
        i_ena = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("ena_low_column", o_column, 0);
        chk("ena_low_head", o_head_flag, 1);
        chk("ena_low_busy", o_busy, 1);
        repeat (7) @(negedge i_clk);
        i_ena = 1'b1;
        wait_q(0, "ena_end");
        cmd(T_RUN, 0);

        // Period 0 -> 1, length 0 -> 16, write pointer wraps 15 -> 0
        cmd(T_MODE, 1); cmd(T_PER, 0); cmd(T_LEN, 0);
        cmd(T_PTR, 15); cmd(T_DATA, 28'h0F0); cmd(T_DATA, 28'h00F); cmd(T_SWAP, 0);
        exp_step(28'h00F, 1, 1); exp_step(28'hAAA, 0, 1);
        for (int i = 2; i < 15; i++) exp_step(28'h0, 0, 1);
        exp_step(28'h0F0, 0, 0);
        cmd(T_RUN, 1);
        wait_q(0, "wrap");
        @(negedge i_clk);
        chk("wrap_done_busy", o_busy, 0);
        chk("wrap_done_column", o_column, 0);
        cmd(T_RUN, 0);

        // Asynchronous reset mid-run
        cmd(T_MODE, 0); cmd(T_PER, 4);
        exp_step(28'h00F, 1, 0);
        cmd(T_RUN, 1);
        wait_q(0, "reset_run");
        @(negedge i_clk);
        chk("pre_reset_busy", o_busy, 1);
        #2 i_rst = 1'b1;
        #1;
        chk("async_rst_column", o_column, 0);
        chk("async_rst_busy", o_busy, 0);
        chk("async_rst_head", o_head_flag, 0);
        chk("async_rst_toggle", o_toggle_sync, 0);
        chk("async_rst_pending", o_swap_pending, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Banks cleared, defaults period 1 and length 16
        cmd(T_MODE, 1);
        for (int i = 0; i < 16; i++) exp_step(28'h0, (i == 0), (i == 15) ? 0 : 1);
        cmd(T_RUN, 1);
        wait_q(0, "post_reset");
        repeat (2) @(negedge i_clk);
        chk("post_reset_busy", o_busy, 0);

        repeat (5) @(negedge i_clk);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Parametrised successor to the single-pattern column trigger generator. It stores up to DEPTH column patterns in a double-buffered bank, loaded from the 32-bit SPI receiver word stream. It steps through the patterns with a programmable dwell period in loop, one-shot or ping-pong mode. It drives the LED column outputs plus toggle-sync and head-flag strobes, and sits between SPI_RECEIVER_32BIT and the LED pins in the array top.

Parameters:
N_COL, 28, number of LED columns driven (1..28)
DEPTH, 16, patterns per bank (power of 2, 2..256)
PERIOD_W, 16, width of dwell-period counter in clocks

Ports:
i_clk  in  1  system clock (internal oscillator)
i_rst  in  1  asynchronous active-high reset
i_ena  in  1  global output enable; low blanks columns and freezes sequencing
i_prm_we  in  1  one-cycle strobe, i_prm valid
i_prm  in  32  command word from SPI receiver
o_column  out  N_COL  current column pattern
o_toggle_sync  out  1  toggles on every displayed step
o_head_flag  out  1  high while pattern index 0 is displayed
o_busy  out  1  high in RUN state
o_swap_pending  out  1  bank swap requested, not yet applied

Behaviour:
- Reset: one clock (i_clk); reset is asynchronous and active-high (i_rst). All outputs 0. Both banks cleared to 0. wptr=0, period=1, length=DEPTH, mode=LOOP, state IDLE, direction up.
- Command decode, one cycle after i_prm_we. op=i_prm[31:28]. Other opcodes are ignored.
  - 0x1 PTR: wptr <= i_prm[log2(DEPTH)-1:0].
  - 0x2 DATA: shadow[wptr] <= i_prm[N_COL-1:0]; wptr <= wptr+1, wrapping DEPTH-1 -> 0.
  - 0x3 PERIOD: staged period <= i_prm[PERIOD_W-1:0]; value 0 is stored as 1.
  - 0x4 LENGTH: staged length <= i_prm[log2(DEPTH):0]; 0 or >DEPTH clamps to DEPTH.
  - 0x5 MODE: i_prm[1:0]: 0 LOOP, 1 ONESHOT, 2 PINGPONG, 3 treated as LOOP.
  - 0x6 SWAP: sets swap_pending.
  - 0x7 RUN: i_prm[0]=1 start, 0 stop.
- Staged period, length and mode are committed at START and at every frame boundary. A write during RUN never alters the current frame.
- States:
  - IDLE -> RUN on START. Apply pending swap, commit config, idx=0, dwell=0, direction up.
  - RUN -> IDLE on STOP (immediate; columns go 0).
  - RUN -> DONE in ONESHOT after the last index completes its dwell.
  - DONE -> RUN on START.
  - DONE -> IDLE on STOP.
  - START while in RUN restarts from idx 0.
- Stepping:
  - Dwell counter increments only when i_ena=1. At dwell==period-1 it clears and idx advances. i_ena=0 freezes idx, dwell and toggle.
  - LOOP: idx LEN-1 -> 0.
  - PINGPONG: reverses direction at 0 and at LEN-1; endpoints shown once per pass; LEN=1 holds idx 0.
  - Frame boundary is any transition into idx 0, or START.
- Swap:
  - If swap_pending at a boundary, active and shadow banks exchange in that cycle, the new active[0] is displayed, and swap_pending clears.
  - SWAP in IDLE or DONE applies immediately.
  - SWAP arriving in the same cycle as a boundary is applied at that boundary.
- Outputs are registered and update one cycle after the idx change.
  - o_column = active[idx] when RUN and i_ena, else 0.
  - o_head_flag = (idx==0) and RUN.
  - o_toggle_sync inverts on each idx change, including START.
  - o_busy = RUN.
- DATA write and display to the same address in the same cycle: no conflict, since writes only ever hit the shadow bank.
- Reset asserted mid-run returns every output to 0 asynchronously; bank contents are lost.

Decomposition:
- Package led_seq_pkg holds:
  - opcode constants OP_PTR..OP_RUN
  - mode encoding LOOP/ONESHOT/PINGPONG
  - state encoding IDLE/RUN/DONE
  - field position constants
- Sub-module led_pattern_bank: two DEPTH x N_COL register arrays with a bank-select bit, a write port into the shadow bank and a combinational read of the active bank, plus a swap input.

Test Plan:
- Reset, then write DATA 0x0000001, 0x0000002, 0x0000004 at PTR 0, LENGTH 3, PERIOD 4, START -> o_column sequence 1,2,4,1 with each value held 4 clocks; o_head_flag high during value 1; toggle inverts every 4 clocks.
- Same setup with MODE PINGPONG, LENGTH 3 -> index sequence 0,1,2,1,0,1; o_head_flag only at index 0.
- MODE ONESHOT, LENGTH 2, PERIOD 3 -> columns show 2 patterns for 3 clocks each, then 0; o_busy falls after clock 6 and state is DONE.
- While running bank A (pattern 0xAAA), load the shadow with 0x555 and issue SWAP mid-frame -> o_swap_pending=1 until the next idx-0 step, then o_column=0x555 and pending=0.
- Drop i_ena low for 10 clocks mid-dwell -> o_column=0, idx/dwell/toggle frozen; on re-enable, the remaining dwell completes unchanged.
- PERIOD 0, LENGTH 0, DATA write with wptr at DEPTH-1 -> period acts as 1 and length as 16; wptr wraps to 0; i_rst asserted mid-run clears all outputs within the same cycle.
